rr_arbitration_unit: RTL and testbench

Parameterised round-robin arbiter granting one of `NUM_CLIENTS` requesters per cycle. A single requester keeps the grant for as long as it requests. Competing requesters rotate in fair order, starting after the last granted client. It sits in front of a shared resource such as a memory or bus port. The grant is combinational from the current requests and a registered "last granted" pointer.

---
 rtl/rr_arbitration_unit_pkg.sv | 9 +
 rtl/rr_priority_pick.sv | 32 +++
 rtl/rr_arbitration_unit.sv | 57 +++++
 tb/tb_rr_arbitration_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbitration_unit_pkg.sv
// Shared helpers for the round-robin arbitration unit.
package rr_arbitration_unit_pkg;

  // Increment a client index with wrap-around at n (n need not be a power of two).
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority pick: grants the first requester at or after start_i.
module rr_priority_pick
  import rr_arbitration_unit_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 8,
  parameter int unsigned BIT_CLIENTS = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] requests_i,
  input  logic [BIT_CLIENTS-1:0] start_i,
  output logic [NUM_CLIENTS-1:0] grant_o,
  output logic                   valid_o
);

  logic [BIT_CLIENTS-1:0] cur;
  logic                   found;

  // Walk indices start_i, start_i+1, ... (mod NUM_CLIENTS); first set request wins.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    cur     = start_i;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      if (!found && requests_i[cur]) begin
        grant_o[cur] = 1'b1;
        found        = 1'b1;
      end
      cur = BIT_CLIENTS'(rr_wrap_inc(32'(cur), NUM_CLIENTS));
    end
    valid_o = found;
  end

endmodule

// File: rtl/rr_arbitration_unit.sv
// Round-robin arbiter: combinational one-hot grant, registered last-granted pointer.
module rr_arbitration_unit
  import rr_arbitration_unit_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] requests,
  output logic [NUM_CLIENTS-1:0] grants
);

  localparam int unsigned BIT_CLIENTS = $clog2(NUM_CLIENTS);
  // Reset so that index 0 is the first scanned.
  localparam logic [BIT_CLIENTS-1:0] LastRst = BIT_CLIENTS'(NUM_CLIENTS - 1);

  logic [BIT_CLIENTS-1:0] last_q, last_d;
  logic [BIT_CLIENTS-1:0] start_idx;
  logic [BIT_CLIENTS-1:0] grant_idx;
  logic                   grant_valid;

  // Scan begins just after the last granted client, so that client is scanned last.
  always_comb begin
    start_idx = BIT_CLIENTS'(rr_wrap_inc(32'(last_q), NUM_CLIENTS));
  end

  rr_priority_pick #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .BIT_CLIENTS(BIT_CLIENTS)
  ) u_pick (
    .requests_i(requests),
    .start_i   (start_idx),
    .grant_o   (grants),
    .valid_o   (grant_valid)
  );

  // One-hot to index encode of the grant; pointer holds when nothing is granted.
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      if (grants[i]) begin
        grant_idx = grant_idx | BIT_CLIENTS'(i);
      end
    end
    last_d = grant_valid ? grant_idx : last_q;
  end

  // Last-granted pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= LastRst;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_rr_arbitration_unit.sv
// Directed self-checking bench for rr_arbitration_unit (8 clients).
module tb_rr_arbitration_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] requests;
  logic [7:0] grants;

  int tests_run;
  int tests_failed;

  rr_arbitration_unit #(
    .NUM_CLIENTS(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .requests(requests),
    .grants  (grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request vector in the low clock phase and let it settle.
  task automatic apply(input logic [7:0] req);
    @(negedge clk);
    requests = req;
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    requests = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (grants !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_idle_grant: got %b expected %b", grants, 8'h00);
    end
    requests = 8'hFF;
    #1;
    tests_run++;
    if (grants !== 8'h01) begin
      tests_failed++;
      $display("FAIL reset_priority: got %b expected %b", grants, 8'h01);
    end
    @(negedge clk);
    requests = 8'h00;
    rst_n    = 1'b1;
  endtask

  task automatic test_lone_requester();
    logic [7:0] req_tab [4] = '{8'h01, 8'h01, 8'h80, 8'h80};
    logic [7:0] exp_tab [4] = '{8'h01, 8'h01, 8'h80, 8'h80};
    for (int i = 0; i < 4; i++) begin
      apply(req_tab[i]);
      tests_run++;
      if (grants !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL lone_requester[%0d]: got %b expected %b", i, grants, exp_tab[i]);
      end
    end
  endtask

  task automatic test_two_way();
    logic [7:0] exp_tab [3] = '{8'h01, 8'h02, 8'h01};
    for (int i = 0; i < 3; i++) begin
      apply(8'h03);
      tests_run++;
      if (grants !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL two_way[%0d]: got %b expected %b", i, grants, exp_tab[i]);
      end
    end
  endtask

  task automatic test_skips();
    logic [7:0] req_tab [3] = '{8'h1C, 8'h70, 8'h03};
    logic [7:0] exp_tab [3] = '{8'h04, 8'h10, 8'h01};
    for (int i = 0; i < 3; i++) begin
      apply(req_tab[i]);
      tests_run++;
      if (grants !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL skips[%0d]: got %b expected %b", i, grants, exp_tab[i]);
      end
    end
  endtask

  task automatic test_idle_and_rotation();
    logic [7:0] exp_tab [10] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                 8'h40, 8'h80, 8'h01, 8'h02, 8'h04};
    apply(8'h00);
    tests_run++;
    if (grants !== 8'h00) begin
      tests_failed++;
      $display("FAIL idle_zero: got %b expected %b", grants, 8'h00);
    end
    for (int i = 0; i < 10; i++) begin
      apply(8'hFF);
      tests_run++;
      if (grants !== exp_tab[i]) begin
        tests_failed++;
        $display("FAIL rotation[%0d]: got %b expected %b", i, grants, exp_tab[i]);
      end
    end
  endtask

  task automatic test_dropped_request();
    apply(8'hF7);
    tests_run++;
    if (grants !== 8'h10) begin
      tests_failed++;
      $display("FAIL dropped_skip: got %b expected %b", grants, 8'h10);
    end
    apply(8'h00);
    tests_run++;
    if (grants !== 8'h00) begin
      tests_failed++;
      $display("FAIL dropped_idle: got %b expected %b", grants, 8'h00);
    end
  endtask

  task automatic test_async_reset();
    // last is 4 here, so a full request set grants client 5.
    apply(8'hFF);
    tests_run++;
    if (grants !== 8'h20) begin
      tests_failed++;
      $display("FAIL pre_reset_grant: got %b expected %b", grants, 8'h20);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (grants !== 8'h01) begin
      tests_failed++;
      $display("FAIL async_reset_immediate: got %b expected %b", grants, 8'h01);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (grants !== 8'h01) begin
      tests_failed++;
      $display("FAIL reset_holds_pointer: got %b expected %b", grants, 8'h01);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (grants !== 8'h01) begin
      tests_failed++;
      $display("FAIL post_reset_grant: got %b expected %b", grants, 8'h01);
    end
    apply(8'hFF);
    tests_run++;
    if (grants !== 8'h02) begin
      tests_failed++;
      $display("FAIL post_reset_next: got %b expected %b", grants, 8'h02);
    end
  endtask

  task automatic test_random_invariant();
    int unsigned model_last;
    logic [7:0]  req;
    logic [7:0]  exp;
    int unsigned idx;
    bit          hit;
    model_last = 1;
    for (int n = 0; n < 200; n++) begin
      req = 8'($urandom_range(0, 255));
      exp = 8'h00;
      hit = 1'b0;
      for (int unsigned k = 1; k <= 8; k++) begin
        idx = (model_last + k) % 8;
        if (!hit && req[idx]) begin
          exp[idx] = 1'b1;
          hit      = 1'b1;
          model_last = model_last;
        end
      end
      apply(req);
      tests_run++;
      if ($countones(grants) != ((req != 8'h00) ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL onehot_invariant[%0d]: req %b got %b", n, req, grants);
      end
      tests_run++;
      if (grants !== exp) begin
        tests_failed++;
        $display("FAIL random_model[%0d]: req %b got %b expected %b", n, req, grants, exp);
      end
      for (int unsigned k = 0; k < 8; k++) begin
        if (exp[k]) model_last = k;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    requests     = 8'h00;
    test_reset();
    test_lone_requester();
    test_two_way();
    test_skips();
    test_idle_and_rotation();
    test_dropped_request();
    test_async_reset();
    test_random_invariant();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
